// File: rtl/uart_rx_ctrl.sv
// UART receiver: oversampled start/data/parity/stop framing with 3-sample majority voting.
// Frame configuration is captured when a start bit is detected and held for the whole frame.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  S_DATA,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  localparam logic [PRESCALE_W-1:0] P8  = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] P16 = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] P32 = PRESCALE_W'(32);
  localparam logic [3:0]            LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t                  state, state_nxt;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [PRESCALE_W-1:0]   p_q;
  logic [PRESCALE_W-1:0]   p_dec;
  logic [PRESCALE_W-1:0]   p_half;
  logic [3:0]              bit_cnt;
  logic [2:0]              samp;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    stop2_q;
  logic                    armed;
  logic                    maj;
  logic                    at_res;
  logic                    at_end;
  logic                    in_frame;
  logic                    last_stop;

  always_comb begin
    p_dec = P8;
    if (Prescale == P16 || Prescale == P32) p_dec = Prescale;
  end

  assign p_half    = p_q >> 1;
  assign at_res    = (edge_cnt == p_half + PRESCALE_W'(2));
  assign at_end    = (edge_cnt == p_q - PRESCALE_W'(1));
  assign maj       = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
  assign in_frame  = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign last_stop = !stop2_q || (bit_cnt == 4'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (armed && !S_DATA) state_nxt = START;
      START: begin
        if (at_res && maj)  state_nxt = IDLE;
        else if (at_end)    state_nxt = DATA;
      end
      DATA:   if (at_end && bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
      PARITY: if (at_end) state_nxt = STOP;
      // The last stop bit exits at its resolve point so a back-to-back start edge is seen in IDLE
      STOP:   if (at_res && last_stop) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      samp       <= '0;
      shreg      <= '0;
      p_q        <= P8;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      armed      <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != IDLE);
      data_valid <= 1'b0;
      if (S_DATA) armed <= 1'b1;

      // The detecting cycle is edge 0 of the start bit
      if (state == IDLE)
        edge_cnt <= (state_nxt == START) ? PRESCALE_W'(1) : '0;
      else if (state_nxt == IDLE || state_nxt == DONE || at_end)
        edge_cnt <= '0;
      else
        edge_cnt <= edge_cnt + PRESCALE_W'(1);

      if (state == IDLE && state_nxt == START) begin
        p_q       <= p_dec;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stop2_q   <= STOP2;
      end

      if (state_nxt != state)
        bit_cnt <= '0;
      else if (in_frame && at_end)
        bit_cnt <= bit_cnt + 4'd1;

      if (in_frame) begin
        if (edge_cnt == p_half - PRESCALE_W'(1)) samp[0] <= S_DATA;
        if (edge_cnt == p_half)                  samp[1] <= S_DATA;
        if (edge_cnt == p_half + PRESCALE_W'(1)) samp[2] <= S_DATA;
      end

      if (at_res) begin
        case (state)
          START: begin
            if (!maj) begin
              par_err <= 1'b0;
              stp_err <= 1'b0;
            end
          end
          DATA:   shreg <= {maj, shreg[DATA_WIDTH-1:1]};
          PARITY: par_err <= (((^shreg) ^ par_typ_q) != maj);
          STOP: begin
            if (!maj) stp_err <= 1'b1;
            if (last_stop && maj && !stp_err && !par_err) begin
              data_valid <= 1'b1;
              P_DATA     <= shreg;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed-frame bench for uart_rx_ctrl: frames are pushed to a scoreboard as they are sent,
// and a negedge monitor checks every data_valid pulse against it, including arrival cycle.
module tb_uart_rx_ctrl;

  logic       CLK;
  logic       RST;
  logic       S_DATA;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } expT;

  expT  sbq[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  logic prevDv = 1'b0;

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .S_DATA(S_DATA), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drives one line level starting at a negedge and holds it for the given number of cycles
  task automatic applyStimulus(input logic level, input int cycles);
    S_DATA = level;
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic [5:0] pre, input int p,
                           input logic pen, input logic ptyp, input logic stp2,
                           input logic badPar, input logic badStop, input logic expectOk);
    expT  e;
    logic parBit;
    Prescale = pre; PAR_EN = pen; PAR_TYP = ptyp; STOP2 = stp2;
    applyStimulus(1'b0, p);
    // Scrambled config mid-frame must be ignored by the receiver
    Prescale = (p == 8) ? 6'd32 : 6'd8; PAR_EN = ~pen; PAR_TYP = ~ptyp; STOP2 = ~stp2;
    for (int i = 0; i < 8; i++) applyStimulus(data[i], p);
    if (pen) begin
      parBit = (^data) ^ ptyp ^ badPar;
      applyStimulus(parBit, p);
    end
    Prescale = pre; PAR_EN = pen; PAR_TYP = ptyp; STOP2 = stp2;
    if (stp2) applyStimulus(1'b1, p);
    if (expectOk) begin
      e.data = data;
      e.cyc  = cyc + p / 2 + 3;
      sbq.push_back(e);
    end
    applyStimulus(~badStop, p);
    S_DATA = 1'b1;
  endtask

  always @(negedge CLK) begin
    expT e;
    if (!RST) begin
      if (prevDv) checkOutput("dv_one_cycle", int'(data_valid), 0);
      if (data_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_dv", int'(data_valid), 0);
        end else begin
          e = sbq.pop_front();
          checkOutput("p_data", int'(P_DATA), int'(e.data));
          checkOutput("dv_flags", int'({par_err, stp_err}), 0);
          checkOutput("dv_latency", cyc, e.cyc);
        end
      end
    end
    prevDv = data_valid && !RST;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] abortByte;
    abortByte = 8'h33;
    RST = 1'b1; S_DATA = 1'b1; Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_p_data", int'(P_DATA), 0);
    checkOutput("rst_dv", int'(data_valid), 0);
    checkOutput("rst_par_err", int'(par_err), 0);
    checkOutput("rst_stp_err", int'(stp_err), 0);
    checkOutput("rst_busy", int'(busy), 0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    $display("[TB] 8N1 P=16 0xA5");
    sendFrame(8'hA5, 6'd16, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge CLK);
    checkOutput("s1_p_data", int'(P_DATA), 'hA5);

    $display("[TB] 8E1 P=8 0x3C with wrong parity");
    sendFrame(8'h3C, 6'd8, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (8) @(negedge CLK);
    checkOutput("s2_par_err", int'(par_err), 1);
    checkOutput("s2_stp_err", int'(stp_err), 0);
    checkOutput("s2_p_data_held", int'(P_DATA), 'hA5);

    $display("[TB] 8N2 P=32 0x81 with second stop bit low");
    sendFrame(8'h81, 6'd32, 32, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (64) @(negedge CLK);
    checkOutput("s3_stp_err", int'(stp_err), 1);
    checkOutput("s3_par_err", int'(par_err), 0);
    checkOutput("s3_p_data_held", int'(P_DATA), 'hA5);
    checkOutput("s3_busy", int'(busy), 0);

    $display("[TB] start glitch P=16");
    Prescale = 6'd16;
    applyStimulus(1'b0, 6);
    checkOutput("s4_busy_high", int'(busy), 1);
    S_DATA = 1'b1;
    repeat (20) @(negedge CLK);
    checkOutput("s4_busy_low", int'(busy), 0);
    checkOutput("s4_stp_err_kept", int'(stp_err), 1);
    checkOutput("s4_par_err_kept", int'(par_err), 0);

    $display("[TB] back-to-back 8O1 P=16 0x55 0xAA");
    sendFrame(8'h55, 6'd16, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    sendFrame(8'hAA, 6'd16, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge CLK);
    checkOutput("s5_p_data", int'(P_DATA), 'hAA);
    checkOutput("s5_flags_clear", int'({par_err, stp_err}), 0);

    $display("[TB] illegal prescale 12 runs at 8x");
    sendFrame(8'h5A, 6'd12, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge CLK);
    checkOutput("s7_p_data", int'(P_DATA), 'h5A);

    $display("[TB] reset during data bit 4, then 0x0F");
    Prescale = 6'd16; PAR_EN = 1'b0; STOP2 = 1'b0;
    applyStimulus(1'b0, 16);
    for (int i = 0; i < 4; i++) applyStimulus(abortByte[i], 16);
    applyStimulus(abortByte[4], 8);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checkOutput("s6_rst_p_data", int'(P_DATA), 0);
    checkOutput("s6_rst_busy", int'(busy), 0);
    RST = 1'b0;
    S_DATA = 1'b1;
    repeat (40) @(negedge CLK);
    sendFrame(8'h0F, 6'd16, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge CLK);
    checkOutput("s6_p_data", int'(P_DATA), 'h0F);

    repeat (4) @(negedge CLK);
    checkOutput("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
